reg_wb_queue: RTL and testbench

Write-back queue directly upstream of the register file's single write port. Accepts register writes from two producers, the ALU (result ready in execute) and the load unit (data returning from memory), in the same cycle. Buffers them in a small in-order FIFO and drains exactly one write per cycle into the register file. Also tells decode whether a register still has a write in flight, so the hazard logic can stall reads of stale data.

---
 rtl/reg_wb_queue.sv | 150 +++++++++++++++
 tb/tb_reg_wb_queue.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/reg_wb_queue.sv
// Write-back queue in front of the register file's single write port: merges
// load and ALU writes in order and reports in-flight destinations to decode.
// Optional same-cycle bypass when the queue is empty: define WB_BYPASS_EN.
module reg_wb_queue #(
    parameter int pw    = 3,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       alu_wr_en,
    input  logic [pw-1:0]              alu_wr_addr,
    input  logic [7:0]                 alu_dat,
    input  logic                       ld_wr_en,
    input  logic [pw-1:0]              ld_wr_addr,
    input  logic [7:0]                 ld_dat,
    output logic                       rf_wr_en,
    output logic [pw-1:0]              rf_wr_addr,
    output logic [7:0]                 rf_dat,
    input  logic [pw-1:0]              chk_addr,
    output logic                       chk_pending,
    output logic                       stall,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       ovf
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [DEPTH-1:0] r_valid;
    logic [pw-1:0]    r_addr [DEPTH];
    logic [7:0]       r_dat  [DEPTH];
    logic [AW-1:0]    r_head;
    logic [AW-1:0]    r_tail;
    logic [CW-1:0]    r_count;
    logic             r_ovf;

    logic             w_pop;
    logic [CW:0]      w_free;
    logic             w_byp_ld;
    logic             w_byp_alu;
    logic             w_ld_req;
    logic             w_alu_req;
    logic             w_ld_acc;
    logic             w_alu_acc;
    logic             w_drop;
    logic [1:0]       w_push_cnt;
    logic [AW-1:0]    w_alu_slot;

    // Head pops every cycle the queue holds anything.
    assign w_pop = (r_count != '0);

    // Slots available to this cycle's pushes, counting the slot freed by the pop.
    assign w_free = (CW+1)'(DEPTH) - {1'b0, r_count} + (CW+1)'(w_pop);

`ifdef WB_BYPASS_EN
    // Only the oldest request skips an empty queue; reset silences it.
    assign w_byp_ld  = ~reset & (r_count == '0) & ld_wr_en;
    assign w_byp_alu = ~reset & (r_count == '0) & ~ld_wr_en & alu_wr_en;
`else
    assign w_byp_ld  = 1'b0;
    assign w_byp_alu = 1'b0;
`endif

    assign w_ld_req   = ld_wr_en  & ~w_byp_ld;
    assign w_alu_req  = alu_wr_en & ~w_byp_alu;

    // Load is older, so it claims space first; ALU needs a slot beyond it.
    assign w_ld_acc   = w_ld_req  & (w_free > '0);
    assign w_alu_acc  = w_alu_req & (w_free > (CW+1)'(w_ld_acc));
    assign w_drop     = (w_ld_req & ~w_ld_acc) | (w_alu_req & ~w_alu_acc);
    assign w_push_cnt = {1'b0, w_ld_acc} + {1'b0, w_alu_acc};
    assign w_alu_slot = w_ld_acc ? r_tail + AW'(1) : r_tail;

    // NOTE: every output of this block gets a default first so no latch is inferred.
    always_comb begin
        rf_wr_en   = 1'b0;
        rf_wr_addr = '0;
        rf_dat     = '0;
        if (w_byp_ld) begin
            rf_wr_en   = 1'b1;
            rf_wr_addr = ld_wr_addr;
            rf_dat     = ld_dat;
        end else if (w_byp_alu) begin
            rf_wr_en   = 1'b1;
            rf_wr_addr = alu_wr_addr;
            rf_dat     = alu_dat;
        end else if (w_pop) begin
            rf_wr_en   = 1'b1;
            rf_wr_addr = r_addr[r_head];
            rf_dat     = r_dat[r_head];
        end
    end

    // The entry retiring this cycle is still pending until its edge.
    always_comb begin
        chk_pending = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (r_valid[i] && (r_addr[i] == chk_addr)) begin
                chk_pending = 1'b1;
            end
        end
    end

    assign stall = (r_count > CW'(DEPTH - 2));
    assign count = r_count;
    assign ovf   = r_ovf;

    // NOTE: state updates use non-blocking assignments so every register
    // samples the pre-edge values of its neighbours.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_valid <= '0;
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
        end else begin
            // Clear before set: when full, the popped slot is refilled this edge.
            if (w_pop) begin
                r_valid[r_head] <= 1'b0;
                r_head          <= r_head + AW'(1);
            end
            if (w_ld_acc) begin
                r_valid[r_tail] <= 1'b1;
            end
            if (w_alu_acc) begin
                r_valid[w_alu_slot] <= 1'b1;
            end
            r_tail  <= r_tail + AW'(w_push_cnt);
            r_count <= r_count + CW'(w_push_cnt) - CW'(w_pop);
            if (w_drop) begin
                r_ovf <= 1'b1;
            end
        end
    end

    // NOTE: the payload array has no reset; the valid bits alone say
    // which slots hold meaningful data.
    always_ff @(posedge clk) begin
        if (w_ld_acc) begin
            r_addr[r_tail] <= ld_wr_addr;
            r_dat[r_tail]  <= ld_dat;
        end
        if (w_alu_acc) begin
            r_addr[w_alu_slot] <= alu_wr_addr;
            r_dat[w_alu_slot]  <= alu_dat;
        end
    end

endmodule

// File: tb/tb_reg_wb_queue.sv
// Bench for reg_wb_queue (default build): directed writes, with a scoreboard
// monitor that checks every register-file write against the expected order.
module tb_reg_wb_queue;

    localparam int PW    = 3;
    localparam int DEPTH = 4;

    typedef struct packed {
        logic [PW-1:0] addr;
        logic [7:0]    dat;
    } wr_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          alu_wr_en;
    logic [PW-1:0] alu_wr_addr;
    logic [7:0]    alu_dat;
    logic          ld_wr_en;
    logic [PW-1:0] ld_wr_addr;
    logic [7:0]    ld_dat;
    logic          rf_wr_en;
    logic [PW-1:0] rf_wr_addr;
    logic [7:0]    rf_dat;
    logic [PW-1:0] chk_addr;
    logic          chk_pending;
    logic          stall;
    logic [2:0]    count;
    logic          ovf;

    int total = 0;
    int bad   = 0;

    wr_t        exp_q[$];
    logic [7:0] rf_model [8];
    bit         written  [8];

    reg_wb_queue #(.pw(PW), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .alu_wr_en(alu_wr_en), .alu_wr_addr(alu_wr_addr), .alu_dat(alu_dat),
        .ld_wr_en(ld_wr_en), .ld_wr_addr(ld_wr_addr), .ld_dat(ld_dat),
        .rf_wr_en(rf_wr_en), .rf_wr_addr(rf_wr_addr), .rf_dat(rf_dat),
        .chk_addr(chk_addr), .chk_pending(chk_pending),
        .stall(stall), .count(count), .ovf(ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int unsigned act, input int unsigned exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    // Present one cycle of requests; queue the expected retirements in order.
    task automatic req(input bit le, input logic [PW-1:0] la, input logic [7:0] ld,
                       input bit ae, input logic [PW-1:0] aa, input logic [7:0] ad,
                       input bit alu_kept);
        ld_wr_en    = le;
        ld_wr_addr  = la;
        ld_dat      = ld;
        alu_wr_en   = ae;
        alu_wr_addr = aa;
        alu_dat     = ad;
        if (le) exp_q.push_back('{addr: la, dat: ld});
        if (ae && alu_kept) exp_q.push_back('{addr: aa, dat: ad});
        cycle();
        ld_wr_en  = 1'b0;
        alu_wr_en = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rf_wr_en"},   32'(rf_wr_en),    0);
        check({tag, "_rf_wr_addr"}, 32'(rf_wr_addr),  0);
        check({tag, "_rf_dat"},     32'(rf_dat),      0);
        check({tag, "_stall"},      32'(stall),       0);
        check({tag, "_chk_pending"},32'(chk_pending), 0);
        check({tag, "_count"},      32'(count),       0);
        check({tag, "_ovf"},        32'(ovf),         0);
    endtask

    // Scoreboard monitor: every write seen mid-cycle must be the next expected one.
    always @(negedge clk) begin
        if (!reset && rf_wr_en) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_write: got addr=%0d dat=%0h, expected no write (t=%0t)",
                         rf_wr_addr, rf_dat, $time);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                check("wb_addr", 32'(rf_wr_addr), 32'(e.addr));
                check("wb_dat",  32'(rf_dat),     32'(e.dat));
            end
            rf_model[rf_wr_addr] = rf_dat;
            written[rf_wr_addr]  = 1'b1;
        end
    end

    initial begin
        reset = 1'b1;
        ld_wr_en = 1'b0; ld_wr_addr = '0; ld_dat = '0;
        alu_wr_en = 1'b0; alu_wr_addr = '0; alu_dat = '0;
        chk_addr = '0;
        for (int i = 0; i < 8; i++) begin
            rf_model[i] = '0;
            written[i]  = 1'b0;
        end
        cycle();
        cycle();
        check_reset_outputs("reset");
        reset = 1'b0;
        cycle();

        // Single ALU write: visible the cycle after its request, then drained.
        req(0, 0, 0, 1, 3'd3, 8'h5A, 1);
        check("alu1_en",    32'(rf_wr_en),   1);
        check("alu1_addr",  32'(rf_wr_addr), 3);
        check("alu1_dat",   32'(rf_dat),     32'h5A);
        check("alu1_count", 32'(count),      1);
        cycle();
        check("alu1_count_after", 32'(count),    0);
        check("alu1_en_after",    32'(rf_wr_en), 0);

        // Load and ALU to the same register: load retires first, ALU wins.
        req(1, 3'd1, 8'h11, 1, 3'd1, 8'h22, 1);
        check("pair_count2", 32'(count),  2);
        check("pair_first",  32'(rf_dat), 32'h11);
        cycle();
        check("pair_count1", 32'(count),  1);
        check("pair_second", 32'(rf_dat), 32'h22);
        cycle();
        check("pair_count0", 32'(count), 0);
        check("pair_reg1",   32'(rf_model[1]), 32'h22);

        // Two requests per cycle until a request finds no slot.
        req(1, 3'd0, 8'hA0, 1, 3'd1, 8'hA1, 1);
        check("ovf_cnt_a",   32'(count), 2);
        check("ovf_stall_a", 32'(stall), 0);
        req(1, 3'd2, 8'hB0, 1, 3'd3, 8'hB1, 1);
        check("ovf_cnt_b",   32'(count), 3);
        check("ovf_stall_b", 32'(stall), 1);
        req(1, 3'd4, 8'hC0, 1, 3'd5, 8'hC1, 1);
        check("ovf_cnt_c",   32'(count), 4);
        check("ovf_flag_c",  32'(ovf),   0);
        req(1, 3'd6, 8'hD0, 1, 3'd7, 8'hD1, 0);
        check("ovf_cnt_d",   32'(count), 4);
        check("ovf_flag_d",  32'(ovf),   1);
        for (int i = 0; i < DEPTH; i++) cycle();
        check("ovf_drained",   32'(count), 0);
        check("ovf_sticky",    32'(ovf),   1);
        check("ovf_dropped_7", 32'(written[7]), 0);
        reset = 1'b1;
        #1;
        check("ovf_reset_clear", 32'(ovf), 0);
        cycle();
        reset = 1'b0;
        cycle();

        // Pending lookup for a queued destination, and a miss.
        chk_addr = 3'd5;
        #1;
        check("chk_before", 32'(chk_pending), 0);
        req(1, 3'd4, 8'h44, 1, 3'd5, 8'h55, 1);
        check("chk_q2",  32'(chk_pending), 1);
        chk_addr = 3'd6;
        #1;
        check("chk_miss_q2", 32'(chk_pending), 0);
        chk_addr = 3'd5;
        #1;
        cycle();
        check("chk_head", 32'(chk_pending), 1);
        chk_addr = 3'd6;
        #1;
        check("chk_miss_head", 32'(chk_pending), 0);
        chk_addr = 3'd5;
        #1;
        cycle();
        check("chk_retired", 32'(chk_pending), 0);

        // Fill to full, then one push per cycle while one pops: pointers wrap.
        req(1, 3'd0, 8'h50, 1, 3'd1, 8'h51, 1);
        req(1, 3'd2, 8'h52, 1, 3'd3, 8'h53, 1);
        req(1, 3'd4, 8'h54, 1, 3'd5, 8'h55, 1);
        check("full_count", 32'(count), 4);
        for (int i = 0; i < 8; i++) begin
            req(1, 3'(i), 8'(8'h60 + i), 0, 0, 0, 1);
            check("steady_count", 32'(count), 4);
        end
        check("steady_ovf", 32'(ovf), 0);
        for (int i = 0; i < DEPTH; i++) cycle();
        check("steady_drained", 32'(count), 0);

        // Reset with three writes queued: they must never retire.
        req(1, 3'd2, 8'hE0, 1, 3'd3, 8'hE1, 1);
        req(1, 3'd4, 8'hE2, 1, 3'd5, 8'hE3, 1);
        check("rst_q_count", 32'(count), 3);
        chk_addr = 3'd5;
        #1;
        reset = 1'b1;
        exp_q.delete();
        #1;
        check_reset_outputs("midrst");
        cycle();
        reset = 1'b0;
        for (int i = 0; i < 4; i++) cycle();
        check("rst_idle_count", 32'(count), 0);

        check("scoreboard_empty", 32'(exp_q.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
